uart_msg_checker: RTL

Simulation-side consumer for a looping UART message source. It deserialises 8N1 frames from the rx line and assembles msg_size_byte bytes into one message, low byte first. Each completed message is compared against an expected value, with per-message match reporting and running good/bad counters. It sits on the far end of the tx line in the simu benches and is self-checking; it has no transmit path.

---
 rtl/uart_msg_checker.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_checker.sv
// uart_msg_checker
// Receives 8N1 UART frames on rx and assembles msg_size_byte bytes into one
// message, low byte first. Each completed message is compared against
// expected_msg. Matches and mismatches are reported per message and tallied
// in saturating counters.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   rx           UART line, idle high, asynchronous to clk
//   expected_msg reference message; byte k is bits [8k+7:8k]
//   msg_out      last completed message
//   msg_valid    one-cycle pulse when msg_out updates
//   msg_match    msg_out == expected_msg at completion, held until next completion
//   frame_error  one-cycle pulse on a bad stop bit
//   timeout      one-cycle pulse when a partial message is dropped
//   good_count   saturating count of matching messages
//   bad_count    saturating count of mismatches, frame errors and timeouts
module uart_msg_checker #(
    parameter int unsigned clk_freq      = 1000000,
    parameter int unsigned baud_rate     = 9600,
    parameter int unsigned msg_size_byte = 2,
    parameter int unsigned timeout_bits  = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic [8*msg_size_byte-1:0]   expected_msg,
    output logic [8*msg_size_byte-1:0]   msg_out,
    output logic                         msg_valid,
    output logic                         msg_match,
    output logic                         frame_error,
    output logic                         timeout,
    output logic [15:0]                  good_count,
    output logic [15:0]                  bad_count
);

    localparam int unsigned BitTicks  = clk_freq / baud_rate;
    localparam int unsigned IdleLimit = timeout_bits * BitTicks;
    localparam int unsigned MsgW      = 8 * msg_size_byte;
    localparam int unsigned BcW       = $clog2(BitTicks);
    localparam int unsigned IcW       = $clog2(IdleLimit + 1);
    localparam int unsigned BiW       = (msg_size_byte > 1) ? $clog2(msg_size_byte) : 1;

    localparam logic [BcW-1:0] BcLast = BcW'(BitTicks - 1);
    localparam logic [BcW-1:0] BcHalf = BcW'(BitTicks / 2 - 1);
    localparam logic [IcW-1:0] IcLast = IcW'(IdleLimit - 1);
    localparam logic [BiW-1:0] BiLast = BiW'(msg_size_byte - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Synchroniser flops reset high so the line looks idle out of reset.
    logic            rx_meta_q, rxs_q;
    state_e          state_q, state_d;
    logic [BcW-1:0]  bc_q, bc_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      data_q, data_d;
    logic [BiW-1:0]  byte_idx_q, byte_idx_d;
    logic [MsgW-1:0] shadow_q, shadow_d;
    logic [IcW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [MsgW-1:0] msg_out_q, msg_out_d;
    logic            msg_valid_q, msg_valid_d;
    logic            msg_match_q, msg_match_d;
    logic            frame_error_q, frame_error_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     good_q, good_d;
    logic [15:0]     bad_q, bad_d;

    always_comb begin
        state_d       = state_q;
        bc_d          = bc_q;
        bit_idx_d     = bit_idx_q;
        data_d        = data_q;
        byte_idx_d    = byte_idx_q;
        shadow_d      = shadow_q;
        idle_cnt_d    = '0;
        msg_out_d     = msg_out_q;
        msg_match_d   = msg_match_q;
        good_d        = good_q;
        bad_d         = bad_q;
        msg_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        timeout_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bc_d = '0;
                // Inter-byte watchdog only runs with a partial message pending.
                if (byte_idx_q != '0) begin
                    if (idle_cnt_q == IcLast) begin
                        timeout_d  = 1'b1;
                        bad_d      = sat_inc(bad_q);
                        byte_idx_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IcW'(1);
                    end
                end
                if (!rxs_q) begin
                    state_d    = StStart;
                    idle_cnt_d = '0;
                end
            end
            StStart: begin
                if (bc_q == BcHalf) begin
                    bc_d      = '0;
                    bit_idx_d = '0;
                    // Still low at mid start bit: real start, later samples land mid-bit.
                    state_d   = rxs_q ? StIdle : StData;
                end else begin
                    bc_d = bc_q + BcW'(1);
                end
            end
            StData: begin
                if (bc_q == BcLast) begin
                    bc_d      = '0;
                    data_d    = {rxs_q, data_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    bc_d = bc_q + BcW'(1);
                end
            end
            StStop: begin
                if (bc_q == BcLast) begin
                    bc_d    = '0;
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    state_d = StIdle;
                    if (rxs_q) begin
                        for (int unsigned k = 0; k < msg_size_byte; k++) begin
                            if (byte_idx_q == BiW'(k)) begin
                                shadow_d[8*k +: 8] = data_q;
                            end
                        end
                        if (byte_idx_q == BiLast) begin
                            byte_idx_d  = '0;
                            msg_out_d   = shadow_d;
                            msg_valid_d = 1'b1;
                            msg_match_d = (shadow_d == expected_msg);
                            if (shadow_d == expected_msg) begin
                                good_d = sat_inc(good_q);
                            end else begin
                                bad_d = sat_inc(bad_q);
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + BiW'(1);
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        bad_d         = sat_inc(bad_q);
                        byte_idx_d    = '0;
                    end
                end else begin
                    bc_d = bc_q + BcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= StIdle;
            bc_q          <= '0;
            bit_idx_q     <= '0;
            data_q        <= '0;
            byte_idx_q    <= '0;
            shadow_q      <= '0;
            idle_cnt_q    <= '0;
            msg_out_q     <= '0;
            msg_valid_q   <= 1'b0;
            msg_match_q   <= 1'b0;
            frame_error_q <= 1'b0;
            timeout_q     <= 1'b0;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            rx_meta_q     <= rx;
            rxs_q         <= rx_meta_q;
            state_q       <= state_d;
            bc_q          <= bc_d;
            bit_idx_q     <= bit_idx_d;
            data_q        <= data_d;
            byte_idx_q    <= byte_idx_d;
            shadow_q      <= shadow_d;
            idle_cnt_q    <= idle_cnt_d;
            msg_out_q     <= msg_out_d;
            msg_valid_q   <= msg_valid_d;
            msg_match_q   <= msg_match_d;
            frame_error_q <= frame_error_d;
            timeout_q     <= timeout_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
        end
    end

    assign msg_out     = msg_out_q;
    assign msg_valid   = msg_valid_q;
    assign msg_match   = msg_match_q;
    assign frame_error = frame_error_q;
    assign timeout     = timeout_q;
    assign good_count  = good_q;
    assign bad_count   = bad_q;

endmodule
